disp_task_sequencer: RTL and testbench
======================================

// Module: disp_task_sequencer
// PURPOSE
//  Frame-level scheduler for the display pipeline: runs N draw tasks (background, test, samples, FFT, ...)
//  in fixed index order via start/done pulse handshakes, then requests a buffer swap and waits for it.
//  Generalised successor of the fixed per-task frame FSM: task count and per-frame enable mask are
//  runtime/parameter driven, with halt-at-frame-boundary, frame counter and optional per-task watchdog.
// PARAMETERS
//  N        4        number of draw tasks; task 0 runs first; N>=1
//  TW       16       watchdog counter width
//  TIMEOUT  16'hffff WAIT cycles before a task is aborted (used only with DISP_SEQ_TIMEOUT_EN)
//  IW       localparam = (N>1) ? $clog2(N) : 1
// PORTS
//  clkSYS      in   1   system clock; the only clock
//  n_reset     in   1   asynchronous active-low reset
//  en          in   N   task enable mask; latched once per frame
//  halt        in   1   hold at frame boundary (after swap) while high
//  start       out  N   one-cycle start pulse to task i
//  done        in   N   one-cycle done pulse from task i
//  swap_start  out  1   one-cycle swap request to the buffer-swap block
//  swap_done   in   1   swap complete pulse
//  busy        out  1   low only in HALT
//  task_idx    out  IW  index of task currently scanned/running
//  frame_cnt   out  16  frames started since reset, wraps ffff->0000
//  timeout     out  N   sticky per-task watchdog flags
// BEHAVIOUR
//  One clock, asynchronous active-low reset (clkSYS, n_reset). All outputs registered.
//  Reset: state SWAP_WAIT, start=0, swap_start=0, busy=1, task_idx=0, frame_cnt=0, timeout=0, en_lat=0.
//   Reset mid-task abandons it; the swap block performs the initial swap itself, so no swap_start after reset.
//  States: SWAP_WAIT, HALT, SCAN, WAIT, SWAP_ISSUE.
//  SWAP_WAIT: on swap_done: halt=1 -> HALT; else latch en_lat<=en, frame_cnt++, task_idx<=0 -> SCAN.
//   halt and swap_done in same cycle: halt wins.
//  HALT: busy=0; when halt=0: latch en, frame_cnt++, task_idx<=0 -> SCAN.
//  SCAN (one cycle per index): en_lat[task_idx]=1 -> WAIT, start[task_idx]=1 on the WAIT entry cycle only;
//   else task_idx==N-1 -> SWAP_ISSUE; else task_idx++ (stay SCAN).
//  WAIT: done[task_idx] accepted every WAIT cycle except the start cycle; on accept:
//   task_idx==N-1 -> SWAP_ISSUE, else task_idx++ -> SCAN. done bits of other indices ignored.
//  SWAP_ISSUE: swap_start=1 for exactly this cycle -> SWAP_WAIT.
//  swap_done outside SWAP_WAIT ignored; en/halt changes mid-frame have no effect until next boundary.
//  Latency: swap_done @t -> start[0] @t+2 if en[0]; all-disabled frame -> swap_start @t+N+1.
//  Frame period with all tasks = sum(task times) + 2N + 1 + swap time.
// CONFIGURATION
//  DISP_SEQ_TIMEOUT_EN defined: TW-bit counter cleared on WAIT entry, increments each WAIT cycle;
//   reaching TIMEOUT without done sets timeout[task_idx] (sticky until reset) and advances exactly as done.
//   done in the same cycle as expiry is treated as done; no flag set.
//  Not defined: no counter; WAIT holds indefinitely; timeout tied to 0.
// TESTING
//  N=4, en=1111, each done 3 cycles after start -> start[0..3] in order, one swap_start, frame_cnt 0->1.
//  en=0101 -> only start[0], start[2]; idx1, idx3 skipped 1 cycle each; swap_start 2 cycles after done[2].
//  en=0000, swap_done @t -> no start, swap_start @t+5, frame_cnt increments.
//  halt=1 with swap_done -> busy=0, no starts; halt drop @u -> start[0] @u+2, busy=1.
//  DISP_SEQ_TIMEOUT_EN, TIMEOUT=8, done[1] never sent -> timeout=0010, start[2] follows; spurious done[3] in WAIT(1) ignored.
//  Assert n_reset during WAIT(2) -> all outputs at reset values; later done[2] ignored; next swap_done restarts at task 0.

Source files
------------

// File: rtl/disp_task_sequencer.sv
// Frame scheduler for the display pipeline: runs enabled draw tasks in index order, then requests a buffer swap.
// Optional per-task watchdog enabled by defining DISP_SEQ_TIMEOUT_EN.
//
// state      | meaning
// SWAP_WAIT  | waiting for swap_done from the buffer-swap block (reset state)
// HALT       | frame boundary hold while halt is high; busy low
// SCAN       | one cycle per index, checks the latched enable bit
// WAIT       | task task_idx running, waiting for its done pulse
// SWAP_ISSUE | swap_start pulse for one cycle
module disp_task_sequencer #(
   parameter int N       = 4,
   parameter int TW      = 16,
   parameter int TIMEOUT = 'hffff,
   localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clkSYS,
   input  logic          n_reset,
   input  logic [N-1:0]  en,
   input  logic          halt,
   output logic [N-1:0]  start,
   input  logic [N-1:0]  done,
   output logic          swap_start,
   input  logic          swap_done,
   output logic          busy,
   output logic [IW-1:0] task_idx,
   output logic [15:0]   frame_cnt,
   output logic [N-1:0]  timeout
);

   typedef enum logic [2:0] {
      S_SWAP_WAIT,
      S_HALT,
      S_SCAN,
      S_WAIT,
      S_SWAP_ISSUE
   } state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] idx_nxt;
   logic [N-1:0]  en_lat, en_lat_nxt;
   logic [15:0]   frame_nxt;
   logic [N-1:0]  start_nxt;
   logic          swap_nxt;
   logic [N-1:0]  to_nxt;
   logic          last_idx;
   logic          start_cycle;
   logic          accept;
   logic          expire;

`ifdef DISP_SEQ_TIMEOUT_EN
   logic [TW-1:0] wd_cnt, wd_nxt;
`endif

   assign last_idx    = (task_idx == IW'(N - 1));
   // start is high only on the WAIT entry cycle; a done seen then belongs to the previous run
   assign start_cycle = |start;

   always_comb begin
      state_nxt  = state;
      idx_nxt    = task_idx;
      en_lat_nxt = en_lat;
      frame_nxt  = frame_cnt;
      start_nxt  = '0;
      swap_nxt   = 1'b0;
      to_nxt     = timeout;
      accept     = 1'b0;
      expire     = 1'b0;
`ifdef DISP_SEQ_TIMEOUT_EN
      wd_nxt     = wd_cnt;
`endif
      case (state)
         S_SWAP_WAIT, S_HALT: begin
            if ((state == S_SWAP_WAIT) ? (swap_done && halt) : 1'b0) begin
               state_nxt = S_HALT;
            end else if ((state == S_SWAP_WAIT) ? swap_done : !halt) begin
               en_lat_nxt = en;
               frame_nxt  = frame_cnt + 16'd1;
               idx_nxt    = '0;
               state_nxt  = S_SCAN;
            end
         end
         S_SCAN: begin
            if (en_lat[task_idx]) begin
               state_nxt           = S_WAIT;
               start_nxt[task_idx] = 1'b1;
`ifdef DISP_SEQ_TIMEOUT_EN
               wd_nxt              = '0;
`endif
            end else if (last_idx) begin
               state_nxt = S_SWAP_ISSUE;
               swap_nxt  = 1'b1;
            end else begin
               idx_nxt = task_idx + IW'(1);
            end
         end
         S_WAIT: begin
            accept = done[task_idx] && !start_cycle;
`ifdef DISP_SEQ_TIMEOUT_EN
            expire = (wd_cnt == TW'(TIMEOUT - 1));
            wd_nxt = wd_cnt + TW'(1);
            if (expire && !accept) to_nxt[task_idx] = 1'b1;
`endif
            if (accept || expire) begin
               if (last_idx) begin
                  state_nxt = S_SWAP_ISSUE;
                  swap_nxt  = 1'b1;
               end else begin
                  idx_nxt   = task_idx + IW'(1);
                  state_nxt = S_SCAN;
               end
            end
         end
         S_SWAP_ISSUE: state_nxt = S_SWAP_WAIT;
         default:      state_nxt = S_SWAP_WAIT;
      endcase
   end

   always_ff @(posedge clkSYS or negedge n_reset) begin
      if (!n_reset) begin
         state      <= S_SWAP_WAIT;
         task_idx   <= '0;
         en_lat     <= '0;
         frame_cnt  <= '0;
         start      <= '0;
         swap_start <= 1'b0;
         busy       <= 1'b1;
         timeout    <= '0;
      end else begin
         state      <= state_nxt;
         task_idx   <= idx_nxt;
         en_lat     <= en_lat_nxt;
         frame_cnt  <= frame_nxt;
         start      <= start_nxt;
         swap_start <= swap_nxt;
         busy       <= (state_nxt != S_HALT);
         timeout    <= to_nxt;
      end
   end

`ifdef DISP_SEQ_TIMEOUT_EN
   always_ff @(posedge clkSYS or negedge n_reset) begin
      if (!n_reset) wd_cnt <= '0;
      else          wd_cnt <= wd_nxt;
   end
`endif

endmodule

// File: tb/tb_disp_task_sequencer.sv
// Self-checking bench for disp_task_sequencer: random task latencies, masks and noise against a cycle-schedule model.
module tb_disp_task_sequencer;
   localparam int N  = 4;
   localparam int TO = 8;

   logic          clkSYS = 1'b0;
   logic          n_reset;
   logic [N-1:0]  en, done, start, timeout;
   logic          halt, swap_start, swap_done, busy;
   logic [1:0]    task_idx;
   logic [15:0]   frame_cnt;

   int            checks = 0;
   int            errors = 0;
   logic [15:0]   exp_frame = '0;
   logic [N-1:0]  exp_to = '0;

   disp_task_sequencer #(.N(N), .TW(16), .TIMEOUT(TO)) dut (
      .clkSYS(clkSYS), .n_reset(n_reset), .en(en), .halt(halt), .start(start), .done(done),
      .swap_start(swap_start), .swap_done(swap_done), .busy(busy), .task_idx(task_idx),
      .frame_cnt(frame_cnt), .timeout(timeout)
   );

   always #5 clkSYS = ~clkSYS;

   // Frame schedule model: cycle 0 carries the trigger (swap_done or halt release); cycle 1 scans index 0.
   // An enabled index scanned at cycle c starts at c+1; the cycle after its done scans the next index.
   // A disabled index costs one cycle; swap_start appears at the cycle after the last index is finished.
   task automatic run_frame(input logic [N-1:0] en_val, input logic [N-1:0] silent,
                            input bit from_halt, input bit noise, input string name);
      int st[N];
      int dn[N];
      int cur;
      int swp;
      logic [N-1:0] exp_start;
      cur = 1;
      for (int i = 0; i < N; i++) begin
         if (en_val[i]) begin
            st[i] = cur + 1;
            dn[i] = st[i] + (silent[i] ? TO - 1 : int'($urandom_range(1, 5)));
            cur   = dn[i] + 1;
            if (silent[i]) exp_to[i] = 1'b1;
         end else begin
            st[i] = -1;
            dn[i] = -1;
            cur   = cur + 1;
         end
      end
      swp       = cur;
      exp_frame = exp_frame + 16'd1;

      @(negedge clkSYS);
      checks++;
      if (start !== '0 || swap_start !== 1'b0) begin
         errors++;
         $display("FAIL %s idle_outputs: start=%b swap_start=%b, required 0000/0", name, start, swap_start);
      end
      en        = en_val;
      done      = '0;
      halt      = 1'b0;
      swap_done = from_halt ? 1'b0 : 1'b1;

      for (int k = 1; k <= swp; k++) begin
         @(negedge clkSYS);
         exp_start = '0;
         for (int i = 0; i < N; i++) if (st[i] == k) exp_start[i] = 1'b1;
         checks++;
         if (start !== exp_start) begin
            errors++;
            $display("FAIL %s start cyc%0d: got %b, required %b", name, k, start, exp_start);
         end
         checks++;
         if (swap_start !== (k == swp)) begin
            errors++;
            $display("FAIL %s swap_start cyc%0d: got %b, required %b", name, k, swap_start, (k == swp));
         end
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy cyc%0d: got %b, required 1", name, k, busy);
         end
         for (int i = 0; i < N; i++) begin
            if (st[i] == k) begin
               checks++;
               if (task_idx !== 2'(i)) begin
                  errors++;
                  $display("FAIL %s task_idx at start%0d: got %0d, required %0d", name, i, task_idx, i);
               end
            end
         end
         if (k == 1) begin
            checks++;
            if (frame_cnt !== exp_frame) begin
               errors++;
               $display("FAIL %s frame_cnt: got %0d, required %0d", name, frame_cnt, exp_frame);
            end
         end
         // next-cycle inputs: scheduled dones, plus noise the sequencer must ignore
         done = '0;
         for (int i = 0; i < N; i++) begin
            if (k == dn[i] && !silent[i]) done[i] = 1'b1;
            if (noise) begin
               if (k == st[i] && $urandom_range(0, 1) == 1) done[i] = 1'b1;
               if ((st[i] < 0 || k < st[i] || k > dn[i]) && $urandom_range(0, 3) == 0) done[i] = 1'b1;
            end
         end
         if (noise && k < swp) begin
            swap_done = ($urandom_range(0, 3) == 0);
            en        = N'($urandom);
            halt      = ($urandom_range(0, 1) == 1);
         end else begin
            swap_done = 1'b0;
            halt      = 1'b0;
         end
      end
      checks++;
      if (timeout !== exp_to) begin
         errors++;
         $display("FAIL %s timeout: got %b, required %b", name, timeout, exp_to);
      end
   endtask

   task automatic test_reset();
      n_reset = 1'b0; en = '0; done = '0; halt = 1'b0; swap_done = 1'b0;
      repeat (3) @(negedge clkSYS);
      checks++;
      if (start !== '0 || swap_start !== 1'b0 || busy !== 1'b1 || task_idx !== '0 ||
          frame_cnt !== '0 || timeout !== '0) begin
         errors++;
         $display("FAIL reset_values: start=%b swap=%b busy=%b idx=%0d frame=%0d to=%b, required 0/0/1/0/0/0",
                  start, swap_start, busy, task_idx, frame_cnt, timeout);
      end
      n_reset = 1'b1;
      repeat (4) begin
         @(negedge clkSYS);
         checks++;
         if (start !== '0 || swap_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: start=%b swap=%b busy=%b, required 0000/0/1", start, swap_start, busy);
         end
      end
   endtask

   task automatic test_all_enabled();
      run_frame(4'b1111, '0, 1'b0, 1'b0, "all_enabled");
   endtask

   task automatic test_sparse_mask();
      run_frame(4'b0101, '0, 1'b0, 1'b1, "sparse_0101");
   endtask

   task automatic test_all_disabled();
      run_frame(4'b0000, '0, 1'b0, 1'b1, "all_disabled");
   endtask

   task automatic test_halt();
      @(negedge clkSYS);
      done = '0; en = 4'b1111; halt = 1'b1; swap_done = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clkSYS);
         swap_done = ($urandom_range(0, 1) == 1);
         checks++;
         if (busy !== 1'b0 || start !== '0 || swap_start !== 1'b0 || frame_cnt !== exp_frame) begin
            errors++;
            $display("FAIL halt_hold cyc%0d: busy=%b start=%b swap=%b frame=%0d, required 0/0000/0/%0d",
                     k, busy, start, swap_start, frame_cnt, exp_frame);
         end
      end
      swap_done = 1'b0;
      run_frame(4'b1011, '0, 1'b1, 1'b1, "halt_release");
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 25; f++) run_frame(N'($urandom), '0, 1'b0, 1'b1, "random");
   endtask

`ifdef DISP_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      run_frame(4'b1111, 4'b0010, 1'b0, 1'b1, "timeout_task1");
      run_frame(4'b1111, '0, 1'b0, 1'b1, "after_timeout");
   endtask
`endif

   task automatic test_reset_mid_task();
      @(negedge clkSYS);
      en = 4'b0100; done = '0; halt = 1'b0; swap_done = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clkSYS);
         swap_done = 1'b0;
         checks++;
         if (start !== ((k == 4) ? 4'b0100 : 4'b0000)) begin
            errors++;
            $display("FAIL midtask_start cyc%0d: got %b, required %b", k, start, (k == 4) ? 4'b0100 : 4'b0000);
         end
      end
      n_reset = 1'b0;
      #1;
      checks++;
      if (start !== '0 || swap_start !== 1'b0 || busy !== 1'b1 || task_idx !== '0 ||
          frame_cnt !== '0 || timeout !== '0) begin
         errors++;
         $display("FAIL midtask_reset_values: start=%b swap=%b busy=%b idx=%0d frame=%0d to=%b",
                  start, swap_start, busy, task_idx, frame_cnt, timeout);
      end
      exp_frame = '0;
      exp_to    = '0;
      @(negedge clkSYS);
      n_reset = 1'b1;
      @(negedge clkSYS);
      done = 4'b0100;
      @(negedge clkSYS);
      done = '0;
      repeat (4) begin
         @(negedge clkSYS);
         checks++;
         if (start !== '0 || swap_start !== 1'b0 || busy !== 1'b1 || frame_cnt !== '0) begin
            errors++;
            $display("FAIL stale_done_ignored: start=%b swap=%b busy=%b frame=%0d, required 0000/0/1/0",
                     start, swap_start, busy, frame_cnt);
         end
      end
   endtask

   task automatic test_back_to_back();
      run_frame(4'b1111, '0, 1'b0, 1'b0, "restart_after_reset");
      run_frame(4'b1001, '0, 1'b0, 1'b1, "back_to_back");
   endtask

   initial begin
      test_reset();
      test_all_enabled();
      test_sparse_mask();
      test_all_disabled();
      test_halt();
      test_random_frames();
`ifdef DISP_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_task();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
